// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM states, port owners, funct3 width codes
// and the width-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MR, OWN_MW} owner_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Code 11 has no RISC-V meaning here and is served as a full word.
  function automatic logic [2:0] byte_count(input logic [2:0] width);
    case (width[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rd_asm.sv
// Read assembler: collects byte beats into little-endian lanes and presents the
// sign/zero-extended word, including the byte arriving in the current cycle.
module mem_rd_asm
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic        capture,
  input  logic [1:0]  lane,
  input  logic [2:0]  width,
  input  logic [7:0]  din,
  output logic [31:0] result
);

  logic [31:0] lanes_q;
  logic [31:0] merged;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q <= '0;
    end else if (en) begin
      if (clear) lanes_q <= '0;
      else if (capture) lanes_q[{lane, 3'b000} +: 8] <= din;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    merged = lanes_q;
    if (capture) merged[{lane, 3'b000} +: 8] = din;
    case (width)
      F3_B:    result = {{24{merged[7]}}, merged[7:0]};
      F3_H:    result = {{16{merged[15]}}, merged[15:0]};
      F3_BU:   result = {24'h000000, merged[7:0]};
      F3_HU:   result = {16'h0000, merged[15:0]};
      default: result = merged;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller arbitrating IF fetches and MA loads/stores.
// Optional branch-flush abort of IF reads: define MEM_CTRL_IF_ABORT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_re,
  input  logic [ADDR_WIDTH-1:0] if_raddr,
  output logic [31:0]           if_rdata,
  output logic                  if_rbusy,
  input  logic                  ma_re,
  input  logic [ADDR_WIDTH-1:0] ma_raddr,
  input  logic [2:0]            ma_rwidth,
  output logic [31:0]           ma_rdata,
  output logic                  ma_rbusy,
  input  logic                  ma_we,
  input  logic [ADDR_WIDTH-1:0] ma_waddr,
  input  logic [2:0]            ma_wwidth,
  input  logic [31:0]           ma_wdata,
  output logic                  ma_wbusy,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  output logic                  mem_wr
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t state, state_d;
  owner_t owner, owner_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]  width_q, n_q, cnt, cnt_inc;
  logic [31:0] wdata_q, rd_result;
  logic        grant_mw, grant_mr, grant_if;
  logic        last_wr, last_rd, capture, abort;
  logic [1:0]  lane;

  // In RD, cycle cnt issues beat cnt and captures beat cnt-LAT.
  always_comb begin
    grant_mw = (state == ST_IDLE) && ma_we;
    grant_mr = (state == ST_IDLE) && !ma_we && ma_re;
    grant_if = (state == ST_IDLE) && !ma_we && !ma_re && if_re;
    cnt_inc  = cnt + 3'd1;
    last_wr  = (cnt_inc == n_q);
    last_rd  = (state == ST_RD) && (cnt == n_q + LAT - 3'd1);
    capture  = (state == ST_RD) && (cnt >= LAT);
    lane     = 2'(cnt - LAT);
`ifdef MEM_CTRL_IF_ABORT_EN
    abort    = (state == ST_RD) && (owner == OWN_IF) && !if_re;
`else
    abort    = 1'b0;
`endif
  end

  always_comb begin
    state_d = state;
    owner_d = owner;
    case (state)
      ST_IDLE: begin
        if (grant_mw) begin
          state_d = ST_WR;
          owner_d = OWN_MW;
        end else if (grant_mr) begin
          state_d = ST_RD;
          owner_d = OWN_MR;
        end else if (grant_if) begin
          state_d = ST_RD;
          owner_d = OWN_IF;
        end
      end
      ST_WR: if (last_wr) state_d = ST_DONE;
      ST_RD: begin
        if (abort) state_d = ST_IDLE;
        else if (last_rd) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
    end else if (rdy) begin
      state <= state_d;
      owner <= owner_d;
    end
  end

  // Bus registers are loaded at grant so beat 0 appears in the first WR/RD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      width_q  <= '0;
      n_q      <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      if_rdata <= '0;
      ma_rdata <= '0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (grant_mw) begin
            addr_q   <= ma_waddr;
            width_q  <= ma_wwidth;
            n_q      <= byte_count(ma_wwidth);
            wdata_q  <= ma_wdata;
            mem_a    <= ma_waddr;
            mem_dout <= ma_wdata[7:0];
          end else if (grant_mr) begin
            addr_q  <= ma_raddr;
            width_q <= ma_rwidth;
            n_q     <= byte_count(ma_rwidth);
            mem_a   <= ma_raddr;
          end else if (grant_if) begin
            addr_q  <= if_raddr;
            width_q <= F3_W;
            n_q     <= byte_count(F3_W);
            mem_a   <= if_raddr;
          end
        end
        ST_WR: begin
          if (!last_wr) begin
            cnt      <= cnt_inc;
            mem_a    <= addr_q + ADDR_WIDTH'(cnt_inc);
            mem_dout <= wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
          end
        end
        ST_RD: begin
          if (!abort) begin
            if (cnt_inc < n_q) mem_a <= addr_q + ADDR_WIDTH'(cnt_inc);
            if (last_rd) begin
              if (owner == OWN_MR) ma_rdata <= rd_result;
              else if_rdata <= rd_result;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  mem_rd_asm u_rd_asm (
    .clk    (clk),
    .rst    (rst),
    .en     (rdy),
    .clear  (state == ST_IDLE),
    .capture(capture && !abort),
    .lane   (lane),
    .width  (width_q),
    .din    (mem_din),
    .result (rd_result)
  );

  assign mem_wr   = (state == ST_WR) && rdy;
  assign if_rbusy = if_re && !((state == ST_DONE) && (owner == OWN_IF));
  assign ma_rbusy = ma_re && !((state == ST_DONE) && (owner == OWN_MR));
  assign ma_wbusy = ma_we && !((state == ST_DONE) && (owner == OWN_MW));

endmodule
